axis_out_packer: RTL and testbench
==================================

Name: axis_out_packer

Overview:
- Downstream neighbour of axis_processor; consumes its OUT_WIDTH-bit output frames (one frame per network timestep reported by RUN).
- Buffers frames in a small FIFO and serialises each frame into 8-bit AXI-Stream beats, least-significant byte first, with tlast on the final byte.
- Feeds the byte-wide host link (UART/DMA) so the processor never stalls on a slow host while the FIFO has room.

Parameters:
- FIFO_DEPTH, 4, number of whole frames buffered; power of 2, >= 2.
- BYTE_WIDTH, 8, output beat width; fixed at 8, carried as a parameter for clarity only.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- arstn  input  1  asynchronous active-low reset.
- s_axis_tdata  input  OUT_WIDTH  output frame from axis_processor.
- s_axis_tvalid  input  1  frame valid.
- s_axis_tready  output  1  packer can accept a frame.
- m_axis_tdata  output  8  serialised byte.
- m_axis_tvalid  output  1  byte valid.
- m_axis_tready  input  1  host accepts byte.
- m_axis_tlast  output  1  high on the last byte of a frame.

Behaviour:
- Constants: NUM_BYTES = ceil(OUT_WIDTH/8); PAD = NUM_BYTES*8 - OUT_WIDTH. Frame is zero-extended by PAD bits at the MSB end. Byte k = padded frame bits [8k+7:8k], k = 0..NUM_BYTES-1.
- Reset (arstn low, asynchronous): FIFO read/write pointers and count = 0. Serialiser state = IDLE. s_axis_tready = 0 while arstn is low, then 1 from the first edge after release. m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0. Any partially sent frame is discarded.
- FIFO:
  - Write on s_axis_tvalid && s_axis_tready.
  - s_axis_tready = !full. It is registered and depends only on count, not on m_axis_tready; no write-when-full even if a read occurs in the same cycle.
  - Read when the serialiser is IDLE, or is in SEND completing the last byte, and the FIFO is not empty.
  - Simultaneous read and write in the same cycle leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Serialiser state machine:
  - IDLE: m_axis_tvalid = 0. If FIFO is non-empty, at the next edge load the head frame into the shift register, set byte_idx = 0, and go to SEND.
  - SEND: m_axis_tvalid = 1, m_axis_tdata = byte byte_idx, m_axis_tlast = (byte_idx == NUM_BYTES-1).
    - On handshake with byte_idx < NUM_BYTES-1: shift right 8 and increment byte_idx.
    - On handshake with the last byte: if FIFO is non-empty, load the next frame and stay in SEND (back-to-back frames, no bubble); otherwise go to IDLE.
  - While m_axis_tvalid && !m_axis_tready, m_axis_tdata and m_axis_tlast hold stable.
- Latency: a frame written at edge N into an empty packer gives its first byte valid after edge N+1. Steady-state throughput is one byte per cycle.
- Degenerate case OUT_WIDTH <= 8: NUM_BYTES = 1 and tlast is high on every beat.
- Ordering: frames leave in arrival order; bytes within a frame are LSB first.

Decomposition:
- processor_config package (existing) supplies OUT_WIDTH.
- Add to that package: localparam OUT_BYTES = (OUT_WIDTH+7)/8, and a typedef out_frame_t = logic [OUT_WIDTH-1:0].
- One sub-module: sync_fifo (WIDTH, DEPTH). Interface: wr_en, wr_data, rd_en, rd_data (show-ahead), full, empty. Reusable on the input path as well.
- Serialiser FSM lives in axis_out_packer.

Test Plan (bench built with OUT_WIDTH = 12, so NUM_BYTES = 2):
- Reset: hold arstn low for 2 cycles mid-stream -> m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0 during reset; s_axis_tready = 1 on the first edge after release; no stale bytes afterwards.
- Single frame: send 12'hABC with m_axis_tready = 1 -> bytes 8'hBC (tlast = 0) then 8'h0A (tlast = 1); first byte valid one cycle after the accept edge.
- Back-to-back frames: send 12'h123, 12'h456, 12'h789 -> bytes 23, 01, 56, 04, 89, 07 on consecutive cycles, tlast on the 2nd, 4th and 6th beats, no bubbles.
- Backpressure/full: m_axis_tready = 0 while sending 6 frames -> s_axis_tready drops after FIFO_DEPTH + 1 = 5 accepts (4 in FIFO plus 1 loaded in the serialiser); tdata and tlast stable while stalled; releasing tready drains all 5 frames in order.
- Random m_axis_tready (50%) with 20 random frames -> scoreboard reassembles every frame exactly; tlast count = 20; pad bits [15:12] are 0 in every second byte.
- Mid-frame reset: assert arstn after the first byte of 12'hFFF -> second byte is never emitted; the next frame 12'h001 gives 01, 00 correctly.

Source files
------------

// File: rtl/processor_config.sv
// rtl/processor_config.sv - shared processor configuration: output frame width and derived types
package processor_config;

  localparam int OUT_WIDTH = 12;
  localparam int OUT_BYTES = (OUT_WIDTH + 7) / 8;

  typedef logic [OUT_WIDTH-1:0] out_frame_t;

  typedef enum logic {
    SER_IDLE,
    SER_SEND
  } ser_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO with full/empty flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/axis_out_packer.sv
// rtl/axis_out_packer.sv - buffers output frames and serialises them LSB-first into byte beats
module axis_out_packer
  import processor_config::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic [OUT_WIDTH-1:0]  s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [BYTE_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int SHIFT_W = OUT_BYTES * BYTE_WIDTH;
  localparam int IDX_W   = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_BYTES - 1);

  ser_state_t         state_q, state_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic               out_of_reset_q, out_of_reset_d;

  out_frame_t fifo_rd_data;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic       fifo_wr_en;
  logic       last_beat;

  // Ready is held low through reset and only follows the FIFO count afterwards
  assign s_axis_tready  = out_of_reset_q && !fifo_full;
  assign fifo_wr_en     = s_axis_tvalid && s_axis_tready;
  assign out_of_reset_d = 1'b1;
  assign last_beat      = (byte_idx_q == LAST_IDX);

  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .arstn   (arstn),
    .wr_en   (fifo_wr_en),
    .wr_data (s_axis_tdata),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    byte_idx_d    = byte_idx_q;
    fifo_rd_en    = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    case (state_q)
      SER_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          shift_d    = SHIFT_W'(fifo_rd_data);
          byte_idx_d = '0;
          state_d    = SER_SEND;
        end
      end
      SER_SEND: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = shift_q[BYTE_WIDTH-1:0];
        m_axis_tlast  = last_beat;
        if (m_axis_tready) begin
          if (!last_beat) begin
            shift_d    = shift_q >> BYTE_WIDTH;
            byte_idx_d = byte_idx_q + 1'b1;
          end else if (!fifo_empty) begin
            // Next frame follows the last byte with no idle cycle
            fifo_rd_en = 1'b1;
            shift_d    = SHIFT_W'(fifo_rd_data);
            byte_idx_d = '0;
          end else begin
            state_d = SER_IDLE;
          end
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q        <= SER_IDLE;
      shift_q        <= '0;
      byte_idx_q     <= '0;
      out_of_reset_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      byte_idx_q     <= byte_idx_d;
      out_of_reset_q <= out_of_reset_d;
    end
  end

endmodule

// File: tb/tb_axis_out_packer.sv
// tb/tb_axis_out_packer.sv - scoreboard bench for axis_out_packer with a byte-level reference model
module tb_axis_out_packer;
  import processor_config::*;

  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 arstn = 1'b0;
  logic [OUT_WIDTH-1:0] s_tdata = '0;
  logic                 s_tvalid = 1'b0;
  logic                 s_tready;
  logic [7:0]           m_tdata;
  logic                 m_tvalid;
  logic                 m_tready = 1'b0;
  logic                 m_tlast;

  int checks = 0;
  int failures = 0;
  int tlast_cnt = 0;

  logic [8:0] exp_q[$];
  logic [8:0] exp_beat;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = '0;
  logic       stall_last = 1'b0;

  always #5 clk = ~clk;

  axis_out_packer #(
    .FIFO_DEPTH (DEPTH),
    .BYTE_WIDTH (8)
  ) dut (
    .clk           (clk),
    .arstn         (arstn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: byte k of a frame is (frame >> 8k) & 0xFF, last flag on the final byte
  task automatic push_frame(input logic [OUT_WIDTH-1:0] f);
    int val;
    val = int'(f);
    for (int k = 0; k < OUT_BYTES; k++)
      exp_q.push_back({(k == OUT_BYTES - 1) ? 1'b1 : 1'b0, 8'((val >> (8 * k)) & 255)});
  endtask

  // Monitor samples on the falling edge; a handshake seen here completes on the next rising edge
  always @(negedge clk) begin
    if (!arstn) begin
      exp_q.delete();
      stall_prev = 1'b0;
      check("rst_tvalid", m_tvalid, 0);
      check("rst_tlast", m_tlast, 0);
      check("rst_tdata", m_tdata, 0);
      check("rst_s_tready", s_tready, 0);
    end else begin
      if (stall_prev) begin
        check("stall_tvalid", m_tvalid, 1);
        check("stall_tdata", m_tdata, stall_data);
        check("stall_tlast", m_tlast, stall_last);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got %0h expected no beat", m_tdata);
        end else begin
          exp_beat = exp_q.pop_front();
          check("beat_tdata", m_tdata, exp_beat[7:0]);
          check("beat_tlast", m_tlast, exp_beat[8]);
        end
        if (m_tlast) begin
          tlast_cnt++;
          check("pad_bits", m_tdata[7:4], 0);
        end
      end
      if (s_tvalid && s_tready) push_frame(s_tdata);
      stall_prev = m_tvalid && !m_tready;
      stall_data = m_tdata;
      stall_last = m_tlast;
    end
  end

  task automatic send_frame(input logic [OUT_WIDTH-1:0] f, input int budget);
    bit ok;
    ok = 1'b0;
    s_tdata  = f;
    s_tvalid = 1'b1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (s_tready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    check("send_accepted", ok, 1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  logic [OUT_WIDTH-1:0] frames [6];
  int acc;
  int sent;
  int issued;
  int tl0;
  int w;

  initial begin
    repeat (2) @(posedge clk);
    #1 arstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_reset", s_tready, 1);
    @(posedge clk);
    #1;

    // Single frame and first-byte latency
    m_tready = 1'b1;
    send_frame(12'hABC, 10);
    @(negedge clk);
    check("lat_not_yet_valid", m_tvalid, 0);
    @(negedge clk);
    check("lat_first_valid", m_tvalid, 1);
    check("lat_first_byte", m_tdata, 8'hBC);
    wait_drain(20);

    // Back-to-back frames with no bubbles
    fork
      begin
        send_frame(12'h123, 10);
        send_frame(12'h456, 10);
        send_frame(12'h789, 10);
      end
      begin
        w = 0;
        @(negedge clk);
        while (!m_tvalid && w < 20) begin
          @(negedge clk);
          w++;
        end
        for (int k = 0; k < 6; k++) begin
          check("b2b_no_bubble", m_tvalid, 1);
          check("b2b_tlast_pos", m_tlast, k % 2);
          @(negedge clk);
        end
      end
    join
    @(posedge clk);
    #1;
    wait_drain(30);

    // Backpressure until the FIFO plus serialiser are full
    for (int k = 0; k < 6; k++) frames[k] = 12'($urandom);
    m_tready = 1'b0;
    acc = 0;
    s_tdata = frames[0];
    s_tvalid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (s_tready) acc++;
      @(posedge clk);
      #1;
      if (acc < 6) s_tdata = frames[acc];
      else s_tvalid = 1'b0;
    end
    check("full_accept_count", acc, DEPTH + 1);
    @(negedge clk);
    check("full_ready_low", s_tready, 0);
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    if (acc < 6) send_frame(frames[acc], 50);
    wait_drain(100);

    // Random frames against random host backpressure
    tl0 = tlast_cnt;
    sent = 0;
    issued = 0;
    for (int c = 0; c < 3000 && sent < 20; c++) begin
      @(negedge clk);
      acc = (s_tvalid && s_tready) ? 1 : 0;
      @(posedge clk);
      #1;
      if (acc == 1) begin
        sent++;
        s_tvalid = 1'b0;
      end
      m_tready = 1'($urandom_range(0, 1));
      if (!s_tvalid && issued < 20 && $urandom_range(0, 3) != 0) begin
        s_tdata  = 12'($urandom);
        s_tvalid = 1'b1;
        issued++;
      end
    end
    s_tvalid = 1'b0;
    check("rand_all_sent", sent, 20);
    m_tready = 1'b1;
    wait_drain(200);
    check("rand_tlast_count", tlast_cnt - tl0, 20);

    // Reset in the middle of a frame discards its remaining byte
    send_frame(12'hFFF, 10);
    w = 0;
    @(negedge clk);
    while (!m_tvalid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("midrst_first_valid", m_tvalid, 1);
    @(posedge clk);
    #1 arstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 arstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ready", s_tready, 1);
    for (int k = 0; k < 3; k++) begin
      check("midrst_no_stale", m_tvalid, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    send_frame(12'h001, 10);
    wait_drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
